// File: rtl/lfsr8_burst_ctrl.sv
// ---------------------------------------------------------------------------------------------
// lfsr8_burst_ctrl
//  Sequencer for an external lfsr8 generator. Folds a streamed ASCII seed string into an 8-bit
//  seed by XOR. On start it pulses the LFSR's load_seed, waits for the seed to appear on the LFSR
//  state, then captures and emits the next N LFSR states as a counted burst.
//
//  Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   i_seed_byte_valid   seed byte presented this cycle
//   i_seed_byte         ASCII seed character (8'h00 does not change the fold)
//   i_seed_byte_last    final byte of the seed string
//   o_seed_ready        seed bytes accepted (IDLE, ACCUM, SEEDED)
//   i_start             begin a burst (honoured only in SEEDED)
//   i_burst_len         number of states to emit, sampled with i_start
//   i_abort             cancel a burst in progress
//   o_busy              high in LOAD, WAIT, RUN
//   o_done              one-cycle pulse on normal burst completion
//   o_seed_loaded       a valid seed is held
//   o_lfsr_load_seed    to lfsr8.load_seed (registered)
//   o_lfsr_seed         to lfsr8.seed (the held seed register)
//   i_lfsr_state        from lfsr8.state
//   o_out_valid         o_out_data / o_out_index valid this cycle
//   o_out_data          captured LFSR state
//   o_out_index         1-based index of the state within the burst
// ---------------------------------------------------------------------------------------------
module lfsr8_burst_ctrl #(
   parameter int unsigned BURST_W  = 8,
   parameter logic [7:0]  ZERO_SUB = 8'h01
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_seed_byte_valid,
   input  logic [7:0]         i_seed_byte,
   input  logic               i_seed_byte_last,
   output logic               o_seed_ready,
   input  logic               i_start,
   input  logic [BURST_W-1:0] i_burst_len,
   input  logic               i_abort,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_seed_loaded,
   output logic               o_lfsr_load_seed,
   output logic [7:0]         o_lfsr_seed,
   input  logic [7:0]         i_lfsr_state,
   output logic               o_out_valid,
   output logic [7:0]         o_out_data,
   output logic [BURST_W-1:0] o_out_index
);

   typedef enum logic [2:0] {
      StIdle,
      StAccum,
      StSeeded,
      StLoad,
      StWait,
      StRun,
      StDone
   } state_e;

   state_e             r_state;
   state_e             w_state_next;

   logic [7:0]         r_acc;
   logic [7:0]         r_seed;
   logic               r_seed_loaded;
   logic [BURST_W-1:0] r_len;
   logic [BURST_W-1:0] r_cnt;
   logic               r_load_seed;
   logic               r_done;
   logic               r_out_valid;
   logic [7:0]         r_out_data;
   logic [BURST_W-1:0] r_out_index;

   logic               w_seed_phase;
   logic               w_start_ok;
   logic               w_take_byte;
   logic [7:0]         w_acc_next;
   logic [7:0]         w_seed_fold;
   logic [BURST_W-1:0] w_cnt_inc;
   logic               w_last_cap;
   logic               w_len_zero;
   logic               w_load_d;
   logic               w_done_d;
   logic               w_cap;

   // Datapath decode shared by next-state and output logic.
   assign w_seed_phase = (r_state == StIdle) || (r_state == StAccum) || (r_state == StSeeded);
   assign w_start_ok   = (r_state == StSeeded) && i_start;
   // A byte colliding with an honoured start is dropped.
   assign w_take_byte  = w_seed_phase && i_seed_byte_valid && !w_start_ok;
   // Only ACCUM continues a string; a byte in IDLE/SEEDED opens a new one. A zero byte leaves
   // the fold unchanged because XOR with 0 is the identity.
   assign w_acc_next   = (r_state == StAccum) ? (r_acc ^ i_seed_byte) : i_seed_byte;
   assign w_seed_fold  = (w_acc_next == 8'h00) ? ZERO_SUB : w_acc_next;
   assign w_cnt_inc    = r_cnt + BURST_W'(1);
   assign w_last_cap   = (w_cnt_inc == r_len);
   assign w_len_zero   = (i_burst_len == '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle, StAccum: begin
            if (w_take_byte) begin
               w_state_next = i_seed_byte_last ? StSeeded : StAccum;
            end
         end
         StSeeded: begin
            if (i_start) begin
               w_state_next = w_len_zero ? StSeeded : StLoad;
            end else if (w_take_byte) begin
               w_state_next = i_seed_byte_last ? StSeeded : StAccum;
            end
         end
         StLoad:  w_state_next = i_abort ? StSeeded : StWait;
         StWait:  w_state_next = i_abort ? StSeeded : StRun;
         StRun: begin
            if (i_abort) begin
               w_state_next = StSeeded;
            end else if (w_last_cap) begin
               w_state_next = StDone;
            end
         end
         StDone:  w_state_next = StSeeded;
         default: w_state_next = StIdle;
      endcase
   end

   // Output logic: direct decodes plus next values of the registered outputs.
   always_comb begin
      o_seed_ready = w_seed_phase;
      o_busy       = (r_state == StLoad) || (r_state == StWait) || (r_state == StRun);
      w_load_d     = w_start_ok && !w_len_zero;
      // The final capture is still emitted under abort; only its done is suppressed.
      w_cap        = (r_state == StRun) && (!i_abort || w_last_cap);
      w_done_d     = (w_start_ok && w_len_zero) || ((r_state == StRun) && w_last_cap && !i_abort);
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc         <= 8'h00;
         r_seed        <= 8'h00;
         r_seed_loaded <= 1'b0;
         r_len         <= '0;
         r_cnt         <= '0;
         r_load_seed   <= 1'b0;
         r_done        <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= 8'h00;
         r_out_index   <= '0;
      end else begin
         if (w_take_byte) begin
            r_acc <= w_acc_next;
            if (i_seed_byte_last) begin
               r_seed        <= w_seed_fold;
               r_seed_loaded <= 1'b1;
            end
         end
         if (w_load_d) begin
            r_len <= i_burst_len;
            r_cnt <= '0;
         end else if (r_state == StRun) begin
            r_cnt <= w_cnt_inc;
         end
         r_load_seed <= w_load_d;
         r_done      <= w_done_d;
         r_out_valid <= w_cap;
         if (w_cap) begin
            r_out_data  <= i_lfsr_state;
            r_out_index <= w_cnt_inc;
         end
      end
   end

   assign o_lfsr_seed      = r_seed;
   assign o_seed_loaded    = r_seed_loaded;
   assign o_lfsr_load_seed = r_load_seed;
   assign o_done           = r_done;
   assign o_out_valid      = r_out_valid;
   assign o_out_data       = r_out_data;
   assign o_out_index      = r_out_index;

endmodule

// File: tb/tb_lfsr8_burst_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_lfsr8_burst_ctrl
//  Directed bench for lfsr8_burst_ctrl. A behavioural lfsr8 (x^8+x^6+x^5+x^4+1, Fibonacci,
//  shift left) is attached to the controller; expected burst data comes from the same step
//  function applied to the seed.
// ---------------------------------------------------------------------------------------------
module tb_lfsr8_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       seed_byte_valid;
   logic [7:0] seed_byte;
   logic       seed_byte_last;
   logic       seed_ready;
   logic       start;
   logic [7:0] burst_len;
   logic       abort;
   logic       busy;
   logic       done;
   logic       seed_loaded;
   logic       lfsr_load_seed;
   logic [7:0] lfsr_seed;
   logic [7:0] lfsr_state;
   logic       out_valid;
   logic [7:0] out_data;
   logic [7:0] out_index;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0] exp_seq [15];

   always #5 clk = ~clk;

   lfsr8_burst_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_seed_byte_valid (seed_byte_valid),
      .i_seed_byte       (seed_byte),
      .i_seed_byte_last  (seed_byte_last),
      .o_seed_ready      (seed_ready),
      .i_start           (start),
      .i_burst_len       (burst_len),
      .i_abort           (abort),
      .o_busy            (busy),
      .o_done            (done),
      .o_seed_loaded     (seed_loaded),
      .o_lfsr_load_seed  (lfsr_load_seed),
      .o_lfsr_seed       (lfsr_seed),
      .i_lfsr_state      (lfsr_state),
      .o_out_valid       (out_valid),
      .o_out_data        (out_data),
      .o_out_index       (out_index)
   );

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Free-running LFSR model driven by the controller.
   always @(posedge clk) begin
      if (lfsr_load_seed) lfsr_state <= lfsr_seed;
      else                lfsr_state <= lfsr_step(lfsr_state);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      seed_byte_valid = 1'b1;
      seed_byte       = b;
      seed_byte_last  = last;
      tick();
      seed_byte_valid = 1'b0;
      seed_byte_last  = 1'b0;
      seed_byte       = 8'h00;
   endtask

   task automatic send_tintareanu();
      logic [7:0] s [10];
      s = '{8'h54, 8'h69, 8'h6E, 8'h74, 8'h61, 8'h72, 8'h65, 8'h61, 8'h6E, 8'h75};
      for (int i = 0; i < 10; i++) begin
         send_byte(s[i], i == 9);
         chk($sformatf("seed_ready_str[%0d]", i), seed_ready, 1);
      end
   endtask

   // Full 15-state burst from seed 8'h2B, starting with the start pulse.
   task automatic burst15(input string tag);
      start     = 1'b1;
      burst_len = 8'd15;
      tick();
      start = 1'b0;
      chk({tag, "_load_pulse"}, lfsr_load_seed, 1);
      chk({tag, "_busy"}, busy, 1);
      tick();
      chk({tag, "_load_off"}, lfsr_load_seed, 0);
      chk({tag, "_wait_nv"}, out_valid, 0);
      tick();
      chk({tag, "_run_nv"}, out_valid, 0);
      tick();
      for (int k = 0; k < 15; k++) begin
         chk($sformatf("%s_valid[%0d]", tag, k), out_valid, 1);
         chk($sformatf("%s_data[%0d]", tag, k), out_data, exp_seq[k]);
         chk($sformatf("%s_index[%0d]", tag, k), out_index, k + 1);
         chk($sformatf("%s_done[%0d]", tag, k), done, (k == 14) ? 1 : 0);
         chk($sformatf("%s_noload[%0d]", tag, k), lfsr_load_seed, 0);
         tick();
      end
      chk({tag, "_end_valid"}, out_valid, 0);
      chk({tag, "_end_done"}, done, 0);
      chk({tag, "_end_busy"}, busy, 0);
      chk({tag, "_end_ready"}, seed_ready, 1);
   endtask

   initial begin
      logic [7:0] s;
      rst_n           = 1'b0;
      seed_byte_valid = 1'b0;
      seed_byte       = 8'h00;
      seed_byte_last  = 1'b0;
      start           = 1'b0;
      burst_len       = 8'd0;
      abort           = 1'b0;

      s = 8'h2B;
      for (int k = 0; k < 15; k++) begin
         s          = lfsr_step(s);
         exp_seq[k] = s;
      end

      // Reset state.
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_seed_loaded", seed_loaded, 0);
      chk("rst_load_seed", lfsr_load_seed, 0);
      chk("rst_lfsr_seed", lfsr_seed, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_index", out_index, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", seed_ready, 1);

      // Seed folding.
      send_tintareanu();
      chk("tint_loaded", seed_loaded, 1);
      chk("tint_seed", lfsr_seed, 8'h2B);
      send_byte(8'h41, 1'b0);
      chk("aa_seed_kept", lfsr_seed, 8'h2B);
      send_byte(8'h41, 1'b1);
      chk("aa_zero_sub", lfsr_seed, 8'h01);
      send_byte(8'h41, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h42, 1'b1);
      chk("a0b_seed", lfsr_seed, 8'h03);
      send_tintareanu();
      chk("reseed", lfsr_seed, 8'h2B);

      // Bursts and replay.
      burst15("b1");
      burst15("b2");

      // Zero-length burst: done only.
      start     = 1'b1;
      burst_len = 8'd0;
      tick();
      start = 1'b0;
      chk("len0_done", done, 1);
      chk("len0_valid", out_valid, 0);
      chk("len0_busy", busy, 0);
      chk("len0_load", lfsr_load_seed, 0);
      tick();
      chk("len0_done_off", done, 0);
      chk("len0_ready", seed_ready, 1);

      // Abort at out_index 5, with start held high during the burst.
      start     = 1'b1;
      burst_len = 8'd15;
      tick();
      chk("ab_load", lfsr_load_seed, 1);
      tick();
      tick();
      tick();
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("ab_index[%0d]", k), out_index, k);
         chk($sformatf("ab_noload[%0d]", k), lfsr_load_seed, 0);
         chk($sformatf("ab_ready[%0d]", k), seed_ready, 0);
         if (k < 5) tick();
      end
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_valid", out_valid, 0);
      chk("ab_done", done, 0);
      chk("ab_busy", busy, 0);
      chk("ab_seeded", seed_ready, 1);
      chk("ab_seed_loaded", seed_loaded, 1);
      tick();
      chk("ab_done_later", done, 0);
      chk("ab_valid_later", out_valid, 0);

      // Asynchronous reset mid-RUN.
      start     = 1'b1;
      burst_len = 8'd15;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("pre_rst_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_index", out_index, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_loaded", seed_loaded, 0);
      chk("arst_lfsr_seed", lfsr_seed, 0);
      chk("arst_load", lfsr_load_seed, 0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("arst_loaded_after", seed_loaded, 0);
      start     = 1'b1;
      burst_len = 8'd5;
      tick();
      start = 1'b0;
      chk("nostart_busy", busy, 0);
      chk("nostart_load", lfsr_load_seed, 0);
      tick();
      tick();
      tick();
      chk("nostart_valid", out_valid, 0);
      chk("nostart_done", done, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
